// File: rtl/bus_pkg.sv
// Shared definitions for the 4-master bus arbiter.
//   BUS_NUM_MASTERS : number of masters on the shared bus
//   master_id_t     : 2-bit master index
//   arb_state_t     : arbiter FSM states
//   id_to_onehot    : master index -> one-hot grant vector
package bus_pkg;
    localparam int BUS_NUM_MASTERS = 4;

    typedef logic [1:0] master_id_t;

    typedef enum logic {
        ARB_IDLE,
        ARB_GRANT
    } arb_state_t;

    function automatic logic [BUS_NUM_MASTERS-1:0] id_to_onehot(master_id_t id);
        return 4'b0001 << id;
    endfunction
endpackage

// File: rtl/bus_arbiter_if.sv
// Request/grant bundle between the bus masters and the arbiter.
//   mN_req_i  : master N request (level, held for the whole transfer)
//   mN_grnt_o : master N grant (registered, one-hot or all-zero)
//   owner_o   : index of the current owner, valid only while busy_o=1
//   busy_o    : any grant asserted
// Modports: master = request side, slave = arbiter side.
interface bus_arbiter_if;
    logic               m0_req_i;
    logic               m1_req_i;
    logic               m2_req_i;
    logic               m3_req_i;
    logic               m0_grnt_o;
    logic               m1_grnt_o;
    logic               m2_grnt_o;
    logic               m3_grnt_o;
    bus_pkg::master_id_t owner_o;
    logic               busy_o;

    modport master (
        output m0_req_i, m1_req_i, m2_req_i, m3_req_i,
        input  m0_grnt_o, m1_grnt_o, m2_grnt_o, m3_grnt_o, owner_o, busy_o
    );

    modport slave (
        input  m0_req_i, m1_req_i, m2_req_i, m3_req_i,
        output m0_grnt_o, m1_grnt_o, m2_grnt_o, m3_grnt_o, owner_o, busy_o
    );
endinterface

// File: rtl/bus_rr_pick.sv
// Combinational round-robin search.
//   req     : request vector, bit N = master N
//   ptr     : first master index to search
//   exclude : mask of masters that may not win this cycle
//   found   : at least one eligible requester
//   winner  : first eligible requester at or after ptr (mod 4)
module bus_rr_pick
    import bus_pkg::*;
(
    input  logic [BUS_NUM_MASTERS-1:0] req,
    input  master_id_t                 ptr,
    input  logic [BUS_NUM_MASTERS-1:0] exclude,
    output logic                       found,
    output master_id_t                 winner
);
    logic [BUS_NUM_MASTERS-1:0]   cand;
    logic [2*BUS_NUM_MASTERS-1:0] cand_dbl;
    logic [BUS_NUM_MASTERS-1:0]   cand_rot;

    // Rotate the candidates so that bit 0 is the master at ptr; the lowest
    // set bit of the rotated vector is then the round-robin winner.
    assign cand     = req & ~exclude;
    assign cand_dbl = {cand, cand} >> ptr;
    assign cand_rot = cand_dbl[BUS_NUM_MASTERS-1:0];

    always_comb begin
        found  = |cand_rot;
        winner = ptr;
        for (int i = BUS_NUM_MASTERS - 1; i >= 0; i--) begin
            if (cand_rot[i]) begin
                winner = ptr + master_id_t'(i);
            end
        end
    end
endmodule

// File: rtl/bus_arbiter.sv
// Round-robin arbiter for the 4-master shared bus with registered one-hot
// grants, hold-until-release ownership and optional forced rotation.
//   clk_i : bus clock
//   rst_i : asynchronous active-high reset
//   bus   : request/grant bundle (slave side)
// Parameters:
//   MAX_TENURE : cycles an owner may hold the bus while another master waits (0 = never preempt)
//   TENURE_W   : tenure counter width, MAX_TENURE < 2**TENURE_W
module bus_arbiter
    import bus_pkg::*;
#(
    parameter int MAX_TENURE = 16,
    parameter int TENURE_W   = 8
) (
    input logic          clk_i,
    input logic          rst_i,
    bus_arbiter_if.slave bus
);
    localparam logic [TENURE_W-1:0] TENURE_LIMIT =
        TENURE_W'((MAX_TENURE > 0) ? MAX_TENURE - 1 : 0);

    arb_state_t                 state_reg,  state_next;
    master_id_t                 owner_reg,  owner_next;
    master_id_t                 ptr_reg,    ptr_next;
    logic [TENURE_W-1:0]        tenure_reg, tenure_next;
    logic [BUS_NUM_MASTERS-1:0] grant_reg,  grant_next;

    logic [BUS_NUM_MASTERS-1:0] req;
    logic [BUS_NUM_MASTERS-1:0] exclude;
    logic                       owner_req;
    logic                       tenure_expired;
    logic                       pick_found;
    master_id_t                 pick_winner;
    logic                       handoff;

    assign req = {bus.m3_req_i, bus.m2_req_i, bus.m1_req_i, bus.m0_req_i};

    // The current owner never competes in its own hand-off search.
    assign exclude   = (state_reg == ARB_GRANT) ? id_to_onehot(owner_reg) : '0;
    assign owner_req = req[owner_reg];

    // ">=" rather than "==" so a waiter that arrives after the counter has
    // already passed the limit still forces rotation.
    assign tenure_expired = (MAX_TENURE > 0) && (tenure_reg >= TENURE_LIMIT);

    bus_rr_pick u_pick (
        .req     (req),
        .ptr     (ptr_reg),
        .exclude (exclude),
        .found   (pick_found),
        .winner  (pick_winner)
    );

    // State register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg  <= ARB_IDLE;
            owner_reg  <= '0;
            ptr_reg    <= '0;
            tenure_reg <= '0;
            grant_reg  <= '0;
        end else begin
            state_reg  <= state_next;
            owner_reg  <= owner_next;
            ptr_reg    <= ptr_next;
            tenure_reg <= tenure_next;
            grant_reg  <= grant_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next  = state_reg;
        owner_next  = owner_reg;
        ptr_next    = ptr_reg;
        tenure_next = tenure_reg;
        handoff     = 1'b0;

        case (state_reg)
            ARB_IDLE: begin
                handoff = pick_found;
            end
            ARB_GRANT: begin
                if (!owner_req) begin
                    // Release: pass straight to the next requester, else go idle.
                    if (pick_found) begin
                        handoff = 1'b1;
                    end else begin
                        state_next = ARB_IDLE;
                    end
                end else if (tenure_expired && pick_found) begin
                    handoff = 1'b1;
                end else if (tenure_reg != '1) begin
                    tenure_next = tenure_reg + 1'b1;
                end
            end
            default: begin
                state_next = ARB_IDLE;
            end
        endcase

        if (handoff) begin
            state_next  = ARB_GRANT;
            owner_next  = pick_winner;
            ptr_next    = pick_winner + 2'd1;
            tenure_next = '0;
        end
    end

    // Output logic: the grant register mirrors the next owner while granted.
    always_comb begin
        grant_next = '0;
        if (state_next == ARB_GRANT) begin
            grant_next = id_to_onehot(owner_next);
        end
    end

    assign bus.m0_grnt_o = grant_reg[0];
    assign bus.m1_grnt_o = grant_reg[1];
    assign bus.m2_grnt_o = grant_reg[2];
    assign bus.m3_grnt_o = grant_reg[3];
    assign bus.owner_o   = owner_reg;
    assign bus.busy_o    = |grant_reg;
endmodule
